// File: rtl/jt89_vol_sched.sv
// jt89_vol_sched: volume scheduler for the JT89 PSG.
// Decodes CPU attenuation writes and holds the four attenuation registers.
// One registered 16-entry attenuation ROM is shared across ch0, ch1, ch2 and
// noise. All four levels reach the mixer together, with a one-cycle mix_en.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   clk_en              sample-rate strobe; starts one scheduling pass
//   wr, din[7:0]        CPU write strobe and SN76489-format byte
//   tone[3:0]           generator outputs: [0]=ch0 [1]=ch1 [2]=ch2 [3]=noise
//   ch0/ch1/ch2/noise   9-bit unsigned levels to the mixer
//   mix_en              one-cycle pulse when a new level set is committed
//   busy                high while a pass is in progress
//   ovf                 sticky: a clk_en arrived during a pass and was dropped
module jt89_vol_sched (
  input  logic       rst,
  input  logic       clk,
  input  logic       clk_en,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic [3:0] tone,
  output logic [8:0] ch0,
  output logic [8:0] ch1,
  output logic [8:0] ch2,
  output logic [8:0] noise,
  output logic       mix_en,
  output logic       busy,
  output logic       ovf
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned ATT_W = 4;
  localparam int unsigned LVL_W = 9;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [NCH-1:0][ATT_W-1:0]     att_q, att_d;
  logic [NCH-1:0][ATT_W-1:0]     snap_att_q, snap_att_d;
  logic [NCH-1:0]                snap_tone_q, snap_tone_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [LVL_W-1:0]              rom_q, rom_d;
  logic [NCH-1:0][LVL_W-1:0]     lvl_q, lvl_d;
  logic [NCH-1:0][LVL_W-1:0]     out_q, out_d;
  logic                          mix_en_q, mix_en_d;
  logic                          busy_q, busy_d;
  logic                          ovf_q, ovf_d;

  logic [ATT_W-1:0]              rom_addr;
  logic [IDX_W-1:0]              cap_idx;

  // 2 dB per step: round(511 * 10^(-k/10)), last entry forced to silence
  function automatic logic [LVL_W-1:0] rom_lut(input logic [ATT_W-1:0] k);
    logic [LVL_W-1:0] v;
    unique case (k)
      4'd0:    v = 9'd511;
      4'd1:    v = 9'd406;
      4'd2:    v = 9'd322;
      4'd3:    v = 9'd256;
      4'd4:    v = 9'd203;
      4'd5:    v = 9'd162;
      4'd6:    v = 9'd128;
      4'd7:    v = 9'd102;
      4'd8:    v = 9'd81;
      4'd9:    v = 9'd64;
      4'd10:   v = 9'd51;
      4'd11:   v = 9'd41;
      4'd12:   v = 9'd32;
      4'd13:   v = 9'd26;
      4'd14:   v = 9'd20;
      default: v = 9'd0;
    endcase
    return v;
  endfunction

  // Address slot is cnt_q; capture slot trails it by one cycle (ROM latency)
  assign rom_addr = snap_att_q[cnt_q[IDX_W-1:0]];
  assign cap_idx  = IDX_W'(cnt_q - CNT_W'(1));

  // Next-state, write decode and datapath
  always_comb begin
    state_d     = state_q;
    att_d       = att_q;
    snap_att_d  = snap_att_q;
    snap_tone_d = snap_tone_q;
    cnt_d       = cnt_q;
    rom_d       = rom_lut(rom_addr);
    lvl_d       = lvl_q;
    out_d       = out_q;
    mix_en_d    = 1'b0;
    busy_d      = busy_q;
    ovf_d       = ovf_q;

    // Attenuation byte: 1 cc 1 dddd; everything else belongs to tone logic
    if (wr && din[7] && din[4]) begin
      att_d[din[6:5]] = din[3:0];
    end

    unique case (state_q)
      S_IDLE: begin
        if (clk_en) begin
          // Snapshot uses the pre-write att value
          snap_att_d  = att_q;
          snap_tone_d = tone;
          cnt_d       = '0;
          busy_d      = 1'b1;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q != '0) begin
          lvl_d[cap_idx] = snap_tone_q[cap_idx] ? rom_q : '0;
        end
        if (cnt_q == CNT_W'(NCH)) begin
          state_d = S_COMMIT;
        end
        if (clk_en) begin
          ovf_d = 1'b1;
        end
      end
      S_COMMIT: begin
        out_d    = lvl_q;
        mix_en_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
        if (clk_en) begin
          ovf_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      att_q       <= {NCH{4'hF}};
      snap_att_q  <= {NCH{4'hF}};
      snap_tone_q <= '0;
      cnt_q       <= '0;
      rom_q       <= '0;
      lvl_q       <= '0;
      out_q       <= '0;
      mix_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      att_q       <= att_d;
      snap_att_q  <= snap_att_d;
      snap_tone_q <= snap_tone_d;
      cnt_q       <= cnt_d;
      rom_q       <= rom_d;
      lvl_q       <= lvl_d;
      out_q       <= out_d;
      mix_en_q    <= mix_en_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ch0    = out_q[0];
  assign ch1    = out_q[1];
  assign ch2    = out_q[2];
  assign noise  = out_q[3];
  assign mix_en = mix_en_q;
  assign busy   = busy_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_jt89_vol_sched.sv
// Bench for jt89_vol_sched: directed scenarios plus randomized passes,
// checked against a table-driven model of attenuation state and levels.
module tb_jt89_vol_sched;

  logic       rst, clk, clk_en, wr;
  logic [7:0] din;
  logic [3:0] tone;
  logic [8:0] ch0, ch1, ch2, noise;
  logic       mix_en, busy, ovf;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int         rom_tbl [16] = '{511, 406, 322, 256, 203, 162, 128, 102,
                               81, 64, 51, 41, 32, 26, 20, 0};
  int         m_att   [4];
  logic [35:0] m_out;
  bit         m_ovf;

  jt89_vol_sched dut (
    .rst    (rst),
    .clk    (clk),
    .clk_en (clk_en),
    .wr     (wr),
    .din    (din),
    .tone   (tone),
    .ch0    (ch0),
    .ch1    (ch1),
    .ch2    (ch2),
    .noise  (noise),
    .mix_en (mix_en),
    .busy   (busy),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] outs();
    return {ch0, ch1, ch2, noise};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_att[i] = 15;
    m_out = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_write(input logic [7:0] b);
    int ch;
    if (b[7] && b[4]) begin
      ch = int'(b[6:5]);
      m_att[ch] = int'(b[3:0]);
    end
  endtask

  function automatic logic [35:0] model_levels(input logic [3:0] t);
    logic [35:0] r;
    int v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      v = t[i] ? rom_tbl[m_att[i]] : 0;
      r[35 - 9*i -: 9] = 9'(v);
    end
    return r;
  endfunction

  task automatic cpu_write(input logic [7:0] b);
    wr = 1'b1;
    din = b;
    tick();
    wr = 1'b0;
    model_write(b);
  endtask

  // One pass: optional write on E0, optional tone churn, optional extra clk_en at edge inj
  task automatic run_pass(input logic [3:0] t, input bit do_wr, input logic [7:0] wb,
                          input bit toggle, input int inj);
    logic [35:0] exp_o, prev;
    bit got;
    int k;
    exp_o = model_levels(t);
    prev  = m_out;
    clk_en = 1'b1;
    tone = t;
    if (do_wr) begin
      wr = 1'b1;
      din = wb;
    end
    tick();
    clk_en = 1'b0;
    wr = 1'b0;
    if (do_wr) model_write(wb);
    n_vec++;
    if ({busy, mix_en} !== 2'b10) begin
      n_err++;
      $display("FAIL start: busy/mix_en=%b expected 10", {busy, mix_en});
    end
    got = 1'b0;
    k = 0;
    for (int i = 1; i <= 10 && !got; i++) begin
      clk_en = (i == inj);
      if (toggle) tone = 4'($urandom);
      tick();
      clk_en = 1'b0;
      k = i;
      if (mix_en) got = 1'b1;
      else begin
        n_vec++;
        if (outs() !== prev) begin
          n_err++;
          $display("FAIL partial: outs=%h expected %h at edge %0d", outs(), prev, i);
        end
      end
    end
    if (inj >= 1 && inj <= 6) m_ovf = 1'b1;
    n_vec++;
    if (!got || k != 6) begin
      n_err++;
      $display("FAIL latency: mix_en seen=%0b at edge %0d expected edge 6", got, k);
    end
    n_vec++;
    if (outs() !== exp_o) begin
      n_err++;
      $display("FAIL levels: got %h expected %h", outs(), exp_o);
    end
    n_vec++;
    if ({busy, ovf} !== {1'b0, m_ovf}) begin
      n_err++;
      $display("FAIL status: busy/ovf=%b expected %b", {busy, ovf}, {1'b0, m_ovf});
    end
    m_out = exp_o;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      n_vec++;
      if ({mix_en, busy} !== 2'b00 || outs() !== m_out) begin
        n_err++;
        $display("FAIL idle: mix_en/busy=%b outs=%h expected 00 %h",
                 {mix_en, busy}, outs(), m_out);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
    n_vec++;
    if ({outs(), mix_en, busy, ovf} !== 39'd0) begin
      n_err++;
      $display("FAIL reset: outs=%h mix/busy/ovf=%b expected all 0",
               outs(), {mix_en, busy, ovf});
    end
    run_pass(4'hF, 1'b0, 8'h00, 1'b0, 0);
    idle_check(2);
  endtask

  task automatic test_levels();
    cpu_write(8'h90);
    cpu_write(8'hB5);
    cpu_write(8'hD7);
    cpu_write(8'hFE);
    run_pass(4'hF, 1'b0, 8'h00, 1'b0, 0);
    n_vec++;
    if (outs() !== {9'd511, 9'd162, 9'd102, 9'd20}) begin
      n_err++;
      $display("FAIL levels_const: got %h expected 511/162/102/20", outs());
    end
    idle_check(1);
    run_pass(4'b0101, 1'b0, 8'h00, 1'b1, 0);
    n_vec++;
    if (outs() !== {9'd511, 9'd0, 9'd102, 9'd0}) begin
      n_err++;
      $display("FAIL tone_mask: got %h expected 511/0/102/0", outs());
    end
  endtask

  task automatic test_ignored_writes();
    cpu_write(8'h80);
    cpu_write(8'h0F);
    cpu_write(8'hA3);
    run_pass(4'hF, 1'b0, 8'h00, 1'b0, 0);
    n_vec++;
    if (outs() !== {9'd511, 9'd162, 9'd102, 9'd20}) begin
      n_err++;
      $display("FAIL ignored: got %h expected 511/162/102/20", outs());
    end
    idle_check(1);
    run_pass(4'hF, 1'b1, 8'h93, 1'b0, 0);
    n_vec++;
    if (ch0 !== 9'd511) begin
      n_err++;
      $display("FAIL wr_at_e0_old: ch0=%0d expected 511", ch0);
    end
    run_pass(4'hF, 1'b0, 8'h00, 1'b0, 0);
    n_vec++;
    if (ch0 !== 9'd256) begin
      n_err++;
      $display("FAIL wr_at_e0_new: ch0=%0d expected 256", ch0);
    end
  endtask

  task automatic test_back_to_back();
    run_pass(4'hF, 1'b0, 8'h00, 1'b0, 3);
    idle_check(10);
    run_pass(4'b1010, 1'b0, 8'h00, 1'b0, 0);
    run_pass(4'b0111, 1'b0, 8'h00, 1'b0, 0);
    n_vec++;
    if (ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky: ovf=%b expected 1", ovf);
    end
  endtask

  task automatic test_reset_midpass();
    clk_en = 1'b1;
    tone = 4'hF;
    tick();
    clk_en = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    n_vec++;
    if ({outs(), mix_en, busy, ovf} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_mid: outs=%h mix/busy/ovf=%b expected all 0",
               outs(), {mix_en, busy, ovf});
    end
    idle_check(8);
    run_pass(4'hF, 1'b0, 8'h00, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int it = 0; it < 30; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 5)); w++) begin
        if ($urandom_range(0, 3) != 0)
          b = {1'b1, 2'($urandom), 1'b1, 4'($urandom)};
        else
          b = 8'($urandom);
        cpu_write(b);
      end
      b = {1'b1, 2'($urandom), 1'b1, 4'($urandom)};
      run_pass(4'($urandom), 1'($urandom), b, 1'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0);
      if ($urandom_range(0, 1) == 1) idle_check(int'($urandom_range(1, 3)));
    end
  endtask

  initial begin
    rst = 1'b1;
    clk_en = 1'b0;
    wr = 1'b0;
    din = 8'h00;
    tone = 4'h0;
    test_reset();
    test_levels();
    test_ignored_writes();
    test_back_to_back();
    test_reset_midpass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
